// File: rtl/srl_ra_ctrl_pkg.sv
// srl_ra_ctrl_pkg
//   Shared types and constants for the SRL random-access table controller.
//   - state_e : controller states (IDLE / LOAD / PLAY)
//   - WRAP_W  : width of the playback wrap counter
package srl_ra_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PLAY = 2'd2
  } state_e;

  localparam int WRAP_W = 16;

endpackage

// File: rtl/srl_ra_ctrl.sv
// srl_ra_ctrl
//   Controller for an externally instantiated SRL table. LOAD shifts DEEP
//   words into the table; PLAY reads indices 0..cfg_last cyclically through
//   the SRL's registered output and presents them on a ready/valid stream.
//
// Ports
//   clk, rst_n          : clock, asynchronous active-low reset
//   load_start          : pulse, begin a table load (IDLE only)
//   play_start          : pulse, begin playback (IDLE and table loaded)
//   stop                : pulse, abort LOAD or PLAY
//   cfg_last            : last playback index, sampled on play_start
//   ld_valid/ld_data/ld_ready : load stream
//   srl_we/srl_data/srl_addr/srl_ce/srl_rstq/srl_dataq : SRL table side
//   out_valid/out_data/out_ready : playback stream
//   loaded, busy, wrap_cnt : status
//
// Build option
//   SRL_RA_CTRL_WRAPCNT_EN : when defined, wrap_cnt counts playback wraps
//   (saturating); otherwise wrap_cnt is tied to zero.
import srl_ra_ctrl_pkg::*;

module srl_ra_ctrl #(
  parameter int WIDTH     = 32,
  parameter int DEEP      = 32,
  parameter int DEEP_BITS = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_start,
  input  logic                 play_start,
  input  logic                 stop,
  input  logic [DEEP_BITS-1:0] cfg_last,
  input  logic                 ld_valid,
  input  logic [WIDTH-1:0]     ld_data,
  output logic                 ld_ready,
  output logic                 srl_we,
  output logic [WIDTH-1:0]     srl_data,
  output logic [DEEP_BITS-1:0] srl_addr,
  output logic                 srl_ce,
  output logic                 srl_rstq,
  input  logic [WIDTH-1:0]     srl_dataq,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  input  logic                 out_ready,
  output logic                 loaded,
  output logic                 busy,
  output logic [WRAP_W-1:0]    wrap_cnt
);

  localparam int                   CNT_W    = $clog2(DEEP + 1);
  localparam logic [DEEP_BITS-1:0] ADDR_TOP = DEEP_BITS'(DEEP - 1);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(DEEP - 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     ld_cnt_q, ld_cnt_d;
  logic                 loaded_q, loaded_d;
  logic [DEEP_BITS-1:0] k_q, k_d;
  logic [DEEP_BITS-1:0] last_q, last_d;
  logic                 out_valid_q, out_valid_d;
  logic                 srl_rstq_q, srl_rstq_d;
  logic                 in_load_s, in_play_s;
  logic [DEEP_BITS-1:0] cfg_clamped_s;

  assign in_load_s = (state_q == LOAD);
  assign in_play_s = (state_q == PLAY);

  // Out-of-range last index plays the whole table.
  assign cfg_clamped_s = (32'(cfg_last) >= 32'(DEEP)) ? ADDR_TOP : cfg_last;

  assign ld_ready  = in_load_s;
  assign srl_we    = in_load_s & ld_valid;
  assign srl_data  = ld_data;
  // The SRL output register is the single holding stage: fetch a new word
  // whenever it is empty or its current word is being consumed.
  assign srl_ce    = in_play_s & (~out_valid_q | out_ready);
  // The first loaded word has been shifted furthest, to position DEEP-1.
  assign srl_addr  = ADDR_TOP - k_q;
  assign srl_rstq  = srl_rstq_q;
  assign out_valid = out_valid_q;
  assign out_data  = srl_dataq;
  assign loaded    = loaded_q;
  assign busy      = (state_q != IDLE);

  // Next-state and next-counter computation for the controller FSM.
  always_comb begin
    state_d     = state_q;
    ld_cnt_d    = ld_cnt_q;
    loaded_d    = loaded_q;
    k_d         = k_q;
    last_d      = last_q;
    out_valid_d = out_valid_q;
    srl_rstq_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_start) begin
          state_d  = LOAD;
          loaded_d = 1'b0;
          ld_cnt_d = {CNT_W{1'b0}};
        end else if (play_start && loaded_q) begin
          state_d     = PLAY;
          k_d         = {DEEP_BITS{1'b0}};
          last_d      = cfg_clamped_s;
          out_valid_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        if (stop) begin
          state_d    = IDLE;
          srl_rstq_d = 1'b1;
          ld_cnt_d   = {CNT_W{1'b0}};
        end else if (ld_valid) begin
          if (ld_cnt_q == CNT_LAST) begin
            state_d  = IDLE;
            loaded_d = 1'b1;
            ld_cnt_d = {CNT_W{1'b0}};
          end else begin
            ld_cnt_d = ld_cnt_q + CNT_W'(1);
          end
        end else begin
          ld_cnt_d = ld_cnt_q;
        end
      end
      PLAY: begin
        if (stop) begin
          state_d     = IDLE;
          srl_rstq_d  = 1'b1;
          out_valid_d = 1'b0;
          k_d         = {DEEP_BITS{1'b0}};
        end else if (srl_ce) begin
          out_valid_d = 1'b1;
          k_d = (k_q == last_q) ? {DEEP_BITS{1'b0}} : (k_q + DEEP_BITS'(1));
        end else begin
          out_valid_d = out_valid_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Controller state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ld_cnt_q    <= {CNT_W{1'b0}};
      loaded_q    <= 1'b0;
      k_q         <= {DEEP_BITS{1'b0}};
      last_q      <= {DEEP_BITS{1'b0}};
      out_valid_q <= 1'b0;
      srl_rstq_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ld_cnt_q    <= ld_cnt_d;
      loaded_q    <= loaded_d;
      k_q         <= k_d;
      last_q      <= last_d;
      out_valid_q <= out_valid_d;
      srl_rstq_q  <= srl_rstq_d;
    end
  end

`ifdef SRL_RA_CTRL_WRAPCNT_EN
  logic [WRAP_W-1:0] wrap_q, wrap_d;

  // Count fetches of the last index (k wrapping back to 0), saturating.
  always_comb begin
    wrap_d = wrap_q;
    if ((state_q == IDLE) && !load_start && play_start && loaded_q) begin
      wrap_d = {WRAP_W{1'b0}};
    end else if (in_play_s && !stop && srl_ce && (k_q == last_q) &&
                 (wrap_q != {WRAP_W{1'b1}})) begin
      wrap_d = wrap_q + WRAP_W'(1);
    end else begin
      wrap_d = wrap_q;
    end
  end

  // Wrap counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrap_q <= {WRAP_W{1'b0}};
    end else begin
      wrap_q <= wrap_d;
    end
  end

  assign wrap_cnt = wrap_q;
`else
  assign wrap_cnt = {WRAP_W{1'b0}};
`endif

endmodule

// File: tb/tb_srl_ra_ctrl.sv
// Testbench for srl_ra_ctrl: SRL table model, behavioural reference model
// checked every cycle, directed scenarios with literal expectations, then
// randomized traffic.
module tb_srl_ra_ctrl;

  localparam int WIDTH = 32;
  localparam int DEEP  = 32;
  localparam int DB    = 5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             load_start = 1'b0, play_start = 1'b0, stop = 1'b0;
  logic [DB-1:0]    cfg_last = '0;
  logic             ld_valid = 1'b0;
  logic [WIDTH-1:0] ld_data = '0;
  logic             ld_ready, srl_we, srl_ce, srl_rstq;
  logic [WIDTH-1:0] srl_data, srl_dataq, out_data;
  logic [DB-1:0]    srl_addr;
  logic             out_valid, loaded, busy;
  logic             out_ready = 1'b0;
  logic [15:0]      wrap_cnt;

  always #5 clk = ~clk;

  srl_ra_ctrl #(.WIDTH(WIDTH), .DEEP(DEEP), .DEEP_BITS(DB)) dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .play_start(play_start),
    .stop(stop), .cfg_last(cfg_last), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_ready(ld_ready), .srl_we(srl_we), .srl_data(srl_data),
    .srl_addr(srl_addr), .srl_ce(srl_ce), .srl_rstq(srl_rstq),
    .srl_dataq(srl_dataq), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .loaded(loaded), .busy(busy), .wrap_cnt(wrap_cnt)
  );

  // SRL table: shift register with addressed read into an output register.
  logic [WIDTH-1:0] sh [DEEP];
  logic [WIDTH-1:0] dataq;
  assign srl_dataq = dataq;
  always @(posedge clk) begin
    if (srl_we) begin
      for (int i = DEEP - 1; i > 0; i--) sh[i] <= sh[i-1];
      sh[0] <= srl_data;
    end
    if (srl_rstq) dataq <= '0;
    else if (srl_ce) dataq <= sh[srl_addr];
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: mode 0=idle 1=load 2=play; f = words fetched since
  // playback began, a = words accepted; the one-word buffer is full iff f>a.
  int m_mode = 0, m_loaded = 0, m_ldcnt = 0, m_L = 0, m_f = 0, m_a = 0;
  int m_rstq = 0, m_wraps = 0;
  logic [WIDTH-1:0] tbl [DEEP];
  logic m_ov, m_ce;

  function automatic int exp_wrap();
`ifdef SRL_RA_CTRL_WRAPCNT_EN
    return m_wraps;
`else
    return 0;
`endif
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      m_mode = 0; m_loaded = 0; m_ldcnt = 0; m_f = 0; m_a = 0;
      m_rstq = 0; m_wraps = 0;
      chk("rst_loaded", loaded, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_srl_we", srl_we, 0);
      chk("rst_srl_ce", srl_ce, 0);
      chk("rst_srl_rstq", srl_rstq, 0);
      chk("rst_ld_ready", ld_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_wrap_cnt", wrap_cnt, 0);
      chk("rst_srl_addr", srl_addr, DEEP - 1);
    end else begin
      m_ov = (m_mode == 2) && (m_f > m_a);
      m_ce = (m_mode == 2) && (!m_ov || out_ready);
      chk("busy", busy, m_mode != 0);
      chk("loaded", loaded, m_loaded);
      chk("ld_ready", ld_ready, m_mode == 1);
      chk("srl_we", srl_we, (m_mode == 1) && ld_valid);
      chk("srl_ce", srl_ce, m_ce);
      chk("srl_rstq", srl_rstq, m_rstq);
      chk("out_valid", out_valid, m_ov);
      chk("wrap_cnt", wrap_cnt, exp_wrap());
      if (m_mode == 1) chk("srl_data", srl_data, ld_data);
      if (m_mode == 2) chk("srl_addr", srl_addr, DEEP - 1 - (m_f % (m_L + 1)));
      if (m_ov) chk("out_data", out_data, tbl[m_a % (m_L + 1)]);
      // advance the model across the coming rising edge
      m_rstq = 0;
      case (m_mode)
        0: begin
          if (load_start) begin
            m_mode = 1; m_loaded = 0; m_ldcnt = 0;
          end else if (play_start && m_loaded != 0) begin
            m_mode = 2; m_L = (int'(cfg_last) >= DEEP) ? DEEP - 1 : int'(cfg_last);
            m_f = 0; m_a = 0; m_wraps = 0;
          end
        end
        1: begin
          if (stop) begin
            m_mode = 0; m_rstq = 1;
          end else if (ld_valid) begin
            tbl[m_ldcnt] = ld_data;
            m_ldcnt++;
            if (m_ldcnt == DEEP) begin m_mode = 0; m_loaded = 1; end
          end
        end
        default: begin
          if (stop) begin
            m_mode = 0; m_rstq = 1;
          end else begin
            if (m_ce) begin
              if ((m_f % (m_L + 1)) == m_L && m_wraps < 65535) m_wraps++;
              m_f++;
            end
            if (m_ov && out_ready) m_a++;
          end
        end
      endcase
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] dq[$];
  int          aq[$];
  int lit_addr[6] = '{31, 30, 29, 28, 31, 30};
  int lit_data[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  int we_cnt, acc;

  initial begin
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // playback request with no table loaded is ignored
    play_start = 1'b1; cfg_last = 5'd3;
    step();
    play_start = 1'b0;
    @(negedge clk) chk("play_unloaded_busy", busy, 0);
    step();

    // load words 0..31
    load_start = 1'b1;
    step();
    load_start = 1'b0; ld_valid = 1'b1; we_cnt = 0;
    for (int i = 0; i < DEEP; i++) begin
      ld_data = i;
      @(negedge clk) if (srl_we) we_cnt++;
      step();
    end
    ld_valid = 1'b0;
    @(negedge clk);
    chk("load_we_pulses", we_cnt, 32);
    chk("load_loaded", loaded, 1);
    chk("load_idle", busy, 0);
    step();

    // playback cfg_last=3, always ready
    cfg_last = 5'd3; play_start = 1'b1; out_ready = 1'b1;
    step();
    play_start = 1'b0;
    dq.delete(); aq.delete();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      aq.push_back(int'(srl_addr));
      if (out_valid && out_ready) dq.push_back(out_data);
      step();
    end
    for (int i = 0; i < 6; i++) chk("play_addr_seq", (i < aq.size()) ? aq[i] : -1, lit_addr[i]);
    for (int i = 0; i < 8; i++) chk("play_data_seq", (i < dq.size()) ? dq[i] : 32'hDEAD, lit_data[i]);

    // stop during playback
    stop = 1'b1;
    step();
    stop = 1'b0;
    @(negedge clk);
    chk("stop_out_valid", out_valid, 0);
    chk("stop_rstq", srl_rstq, 1);
    chk("stop_busy", busy, 0);
    step();
    @(negedge clk) chk("stop_rstq_one_cycle", srl_rstq, 0);
    step();

    // playback with ready toggling 1010...
    cfg_last = 5'd3; play_start = 1'b1;
    step();
    play_start = 1'b0; dq.delete();
    for (int i = 0; i < 24; i++) begin
      out_ready = (i % 2 == 0);
      @(negedge clk) if (out_valid && out_ready) dq.push_back(out_data);
      step();
    end
    for (int i = 0; i < 8; i++) chk("toggle_data_seq", (i < dq.size()) ? dq[i] : 32'hDEAD, lit_data[i]);
    stop = 1'b1; step(); stop = 1'b0; step();

    // wrap counting: cfg_last=1, ten accepted outputs
    cfg_last = 5'd1; play_start = 1'b1; out_ready = 1'b1;
    step();
    play_start = 1'b0; acc = 0;
    for (int i = 0; i < 40 && acc < 10; i++) begin
      @(negedge clk) if (out_valid && out_ready) acc++;
      step();
    end
    chk("wrap_accepts", acc, 10);
`ifdef SRL_RA_CTRL_WRAPCNT_EN
    chk("wrap_cnt_lit", wrap_cnt, 5);
`else
    chk("wrap_cnt_lit", wrap_cnt, 0);
`endif
    stop = 1'b1; out_ready = 1'b0; step(); stop = 1'b0; step();

    // reset in the middle of a load
    load_start = 1'b1; step(); load_start = 1'b0;
    ld_valid = 1'b1; repeat (5) step();
    ld_valid = 1'b0; rst_n = 1'b0;
    step();
    @(negedge clk);
    chk("midload_rst_loaded", loaded, 0);
    chk("midload_rst_busy", busy, 0);
    rst_n = 1'b1;
    step();
    play_start = 1'b1; step(); play_start = 1'b0;
    @(negedge clk) chk("play_after_rst_ignored", busy, 0);
    step();

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      load_start = ($urandom_range(0, 40) == 0);
      play_start = ($urandom_range(0, 30) == 0);
      stop       = ($urandom_range(0, 150) == 0);
      ld_valid   = ($urandom_range(0, 3) != 0);
      ld_data    = $urandom;
      out_ready  = $urandom_range(0, 1);
      cfg_last   = DB'($urandom_range(0, DEEP - 1));
      rst_n      = ($urandom_range(0, 900) != 0);
      step();
    end
    load_start = 1'b0; play_start = 1'b0; stop = 1'b0; ld_valid = 1'b0;
    rst_n = 1'b1;
    step(); step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
